alu_arbiter: RTL and testbench

- Shares one instance of the team's combinational ALU (parameter n=N) between two requesters.
- Round-robin arbitration on valid/ready request channels; one operation in flight at a time.
- Registers operands and result so the ALU sits between two flop stages.
- Returns the result on a single valid/ready response channel tagged with the requester ID.

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters, the ALU arbiter and its consumer
//
// Purpose: groups both requester channels (valid/ready/op/x/y), the tagged
// response channel (valid/ready/id/f/err) and the busy status.
// Modports:
//   slave  - the arbiter: takes requests and rsp_ready, drives readies, response and busy.
//   master - requesters plus response consumer: the mirror image.
// Parameter N is the operand width; results are 2*N bits.

interface alu_arbiter_if #(
    parameter int N = 16
);
    logic           req0_valid;
    logic           req0_ready;
    logic [2:0]     req0_op;
    logic [N-1:0]   req0_x;
    logic [N-1:0]   req0_y;

    logic           req1_valid;
    logic           req1_ready;
    logic [2:0]     req1_op;
    logic [N-1:0]   req1_x;
    logic [N-1:0]   req1_y;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [2*N-1:0] rsp_f;
    logic           rsp_err;

    logic           busy;

    modport slave (
        input  req0_valid, req0_op, req0_x, req0_y,
        input  req1_valid, req1_op, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_f, rsp_err,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_x, req0_y,
        output req1_valid, req1_op, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_f, rsp_err,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Purpose: accepts one operation at a time from requester 0 or 1 (round-robin
// when both are valid), registers the operands, evaluates them in a
// combinational ALU, registers the 2N-bit result and returns it on a single
// response channel tagged with the requester id.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - alu_arbiter_if.slave: req0_*/req1_* request channels, rsp_* response
//         channel, busy (high whenever the FSM is not IDLE)
// Opcodes: 000 add, 001 sub, 010 mul, 011 {quotient, remainder},
//          100 or, 101 and, 110 ~x, 111 ~y.
// Optional feature macro: ALU_ARB_DIV0_CHK_EN
//   defined   - divide by zero returns rsp_f=0 with rsp_err=1
//   undefined - rsp_err is tied low and divide by zero returns the raw ALU output

module alu_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;       // 0: favour requester 0, 1: favour requester 1
    logic [2:0]     op_q, op_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic           id_q, id_d;
    logic [2*N-1:0] f_q, f_d;

`ifdef ALU_ARB_DIV0_CHK_EN
    logic           div0_q, div0_d;
    logic           err_q, err_d;
`endif

    logic           gnt0;
    logic           gnt1;

    // ------------------------------------------------------------------
    // ALU: fed only from the operand registers
    // ------------------------------------------------------------------
    logic [2*N-1:0]        ext_x;
    logic [2*N-1:0]        ext_y;
    logic signed [N-1:0]   sx;
    logic signed [N-1:0]   sy;
    logic signed [N-1:0]   quot;
    logic signed [N-1:0]   rem;
    logic [2*N-1:0]        alu_f;

    assign ext_x = {{N{x_q[N-1]}}, x_q};
    assign ext_y = {{N{y_q[N-1]}}, y_q};
    assign sx    = x_q;
    assign sy    = y_q;
    assign quot  = sx / sy;
    assign rem   = sx % sy;

    always_comb begin
        alu_f = '0;
        case (op_q)
            3'b000:  alu_f = ext_x + ext_y;
            3'b001:  alu_f = ext_x - ext_y;
            // Low 2N bits of the sign-extended product equal the signed product.
            3'b010:  alu_f = ext_x * ext_y;
            3'b011:  alu_f = {quot, rem};
            3'b100:  alu_f = {{N{1'b0}}, x_q | y_q};
            3'b101:  alu_f = {{N{1'b0}}, x_q & y_q};
            3'b110:  alu_f = {{N{1'b0}}, ~x_q};
            default: alu_f = {{N{1'b0}}, ~y_q};
        endcase
    end

    // ------------------------------------------------------------------
    // Next state, grant and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        f_d     = f_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
`ifdef ALU_ARB_DIV0_CHK_EN
        div0_d  = div0_q;
        err_d   = err_q;
`endif

        case (state_q)
            IDLE: begin
                // A grant implies valid, so grant doubles as ready and accept.
                gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
                gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
                if (gnt0) begin
                    op_d    = bus.req0_op;
                    x_d     = bus.req0_x;
                    y_d     = bus.req0_y;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = EXEC;
`ifdef ALU_ARB_DIV0_CHK_EN
                    div0_d  = (bus.req0_op == 3'b011) && (bus.req0_y == '0);
`endif
                end else if (gnt1) begin
                    op_d    = bus.req1_op;
                    x_d     = bus.req1_x;
                    y_d     = bus.req1_y;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = EXEC;
`ifdef ALU_ARB_DIV0_CHK_EN
                    div0_d  = (bus.req1_op == 3'b011) && (bus.req1_y == '0);
`endif
                end
            end

            EXEC: begin
`ifdef ALU_ARB_DIV0_CHK_EN
                f_d   = div0_q ? '0 : alu_f;
                err_d = div0_q;
`else
                f_d   = alu_f;
`endif
                state_d = RESP;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= 1'b0;
            f_q     <= '0;
`ifdef ALU_ARB_DIV0_CHK_EN
            div0_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            f_q     <= f_d;
`ifdef ALU_ARB_DIV0_CHK_EN
            div0_q  <= div0_d;
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_f      = f_q;
    assign bus.busy       = (state_q != IDLE);
`ifdef ALU_ARB_DIV0_CHK_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_arbiter_if #(.N(16)) bus ();

    alu_arbiter #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_x = 16'd0; bus.req0_y = 16'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_x = 16'd0; bus.req1_y = 16'd0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps negedge by negedge until rsp_valid, giving up after 20 cycles.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (bus.rsp_valid === 1'b1) ok = 1'b1;
                else @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.rsp_f !== 32'h0) begin failures++; $display("FAIL reset_rsp_f got=%0h exp=0", bus.rsp_f); end
        checks++; if (bus.rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%0h exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0h exp=0", bus.rsp_err); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%0b exp=00", {bus.req0_ready, bus.req1_ready}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        bus.req0_op = 3'b000; bus.req0_x = 16'd5; bus.req0_y = 16'd7;
        bus.req0_valid = 1'b1; bus.rsp_ready = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL add_ready got=%0b exp=10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        checks++; if ({bus.busy, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL add_exec busy,valid got=%0b exp=10", {bus.busy, bus.rsp_valid}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL add_latency rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_f !== 32'd12) begin failures++; $display("FAIL add_f got=%0h exp=c", bus.rsp_f); end
        checks++; if ({bus.rsp_id, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL add_id_err got=%0b exp=00", {bus.rsp_id, bus.rsp_err}); end
        @(negedge clk);
        checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin failures++; $display("FAIL add_done busy,valid got=%0b exp=00", {bus.busy, bus.rsp_valid}); end
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        bus.req0_op = 3'b010; bus.req0_x = 16'hFFFD; bus.req0_y = 16'd4;
        bus.req1_op = 3'b001; bus.req1_x = 16'd10;   bus.req1_y = 16'd15;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL cont_grant0 got=%0b exp=10", {bus.req0_ready, bus.req1_ready}); end
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_rsp0_timeout got=timeout exp=rsp_valid"); end
        checks++; if ({bus.rsp_id, bus.rsp_f} !== {1'b0, 32'hFFFF_FFF4}) begin failures++; $display("FAIL cont_rsp0 id=%0h f=%0h exp id=0 f=fffffff4", bus.rsp_id, bus.rsp_f); end
        @(negedge clk);
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_rsp1_timeout got=timeout exp=rsp_valid"); end
        checks++; if ({bus.rsp_id, bus.rsp_f} !== {1'b1, 32'hFFFF_FFFB}) begin failures++; $display("FAIL cont_rsp1 id=%0h f=%0h exp id=1 f=fffffffb", bus.rsp_id, bus.rsp_f); end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_idle busy got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        idle_inputs();
        bus.req1_op = 3'b100; bus.req1_x = 16'h00F0; bus.req1_y = 16'h0F00;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=timeout exp=rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_f} !== {4'b1100, 1'b1, 32'h0000_0FF0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%0h busy=%0h rdy=%0b id=%0h f=%0h exp valid=1 busy=1 rdy=00 id=1 f=ff0",
                         i, bus.rsp_valid, bus.busy, {bus.req0_ready, bus.req1_ready}, bus.rsp_id, bus.rsp_f);
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL bp_release valid,busy got=%0b exp=00", {bus.rsp_valid, bus.busy}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL bp_no_extra cyc=%0d got=%0b exp=00", i, {bus.rsp_valid, bus.busy}); end
        end
    endtask

    task automatic test_divide();
        bit ok;
        idle_inputs();
        bus.rsp_ready = 1'b1;
        bus.req0_op = 3'b011; bus.req0_x = 16'd17; bus.req0_y = 16'd5; bus.req0_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL div_timeout got=timeout exp=rsp_valid"); end
        checks++; if ({bus.rsp_err, bus.rsp_f} !== {1'b0, 32'h0003_0002}) begin failures++; $display("FAIL div_f err=%0h f=%0h exp err=0 f=30002", bus.rsp_err, bus.rsp_f); end
        @(negedge clk);
`ifdef ALU_ARB_DIV0_CHK_EN
        bus.req0_y = 16'd0; bus.req0_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL div0_latency rsp_valid got=%0h exp=1", bus.rsp_valid); end
        checks++; if ({bus.rsp_err, bus.rsp_f} !== {1'b1, 32'h0}) begin failures++; $display("FAIL div0 err=%0h f=%0h exp err=1 f=0", bus.rsp_err, bus.rsp_f); end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_midop();
        bit ok;
        idle_inputs();
        bus.rsp_ready = 1'b1;
        bus.req0_op = 3'b000; bus.req0_x = 16'd1; bus.req0_y = 16'd1; bus.req0_valid = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_exec busy got=%0h exp=1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin failures++; $display("FAIL rmid_abort valid,busy got=%0b exp=00", {bus.rsp_valid, bus.busy}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp cyc=%0d got=%0h exp=0", i, bus.rsp_valid); end
        end
        bus.req0_op = 3'b000; bus.req0_x = 16'd2;    bus.req0_y = 16'd3;
        bus.req1_op = 3'b101; bus.req1_x = 16'h00FF; bus.req1_y = 16'h000F;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_ptr rdy got=%0b exp=10", {bus.req0_ready, bus.req1_ready}); end
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=timeout exp=rsp_valid"); end
        checks++; if ({bus.rsp_id, bus.rsp_f} !== {1'b0, 32'd5}) begin failures++; $display("FAIL rmid_rsp id=%0h f=%0h exp id=0 f=5", bus.rsp_id, bus.rsp_f); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n0;
        int n1;
        logic exp_id;
        n0 = 0; n1 = 0;
        idle_inputs();
        bus.req0_op = 3'b000; bus.req0_x = 16'd100; bus.req0_y = 16'd1;
        bus.req1_op = 3'b001; bus.req1_x = 16'd0;   bus.req1_y = 16'd1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=timeout exp=rsp_valid"); end
        // The previous accept was requester 0, so requester 1 leads here.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (3) @(negedge clk);
            exp_id = (k % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_f} !== {1'b1, exp_id, (exp_id ? 32'hFFFF_FFFF : 32'd101)}) begin
                failures++;
                $display("FAIL b2b_rsp k=%0d valid=%0h id=%0h f=%0h exp valid=1 id=%0h f=%0h",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_f, exp_id, (exp_id ? 32'hFFFF_FFFF : 32'd101));
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_id === 1'b0) n0++;
            if (bus.rsp_valid === 1'b1 && bus.rsp_id === 1'b1) n1++;
            if (k == 7) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (n0 !== 4 || n1 !== 4) begin failures++; $display("FAIL b2b_counts got n0=%0d n1=%0d exp 4/4", n0, n1); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy got=%0h exp=0", bus.busy); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_divide();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
